normal_light_dot: RTL and testbench
===================================

Name: normal_light_dot

Overview:
- Flat-shading stage directly downstream of triangle_normal.
- Takes each face normal (vec3_f16) plus a triangle tag and computes the Lambert term max(0, N·L) in f16 against a programmable light direction.
- Results are buffered and delivered with a valid/ready handshake and a facing flag.
- The float IP pipelines cannot stall, so input acceptance is governed by a credit counter. Results are never dropped.

Parameters:
- MUL_LAT, 6, latency of float_multiply in cycles.
- ADD_LAT, 11, latency of float_add_sub in cycles.
- TAG_W, 16, width of the triangle tag sideband.
- DEPTH, 32, output FIFO entries. Must be >= MUL_LAT+2*ADD_LAT+1 for full throughput.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- normal  in  48  vec3_f16 face normal, {z,y,x} as elements [2],[1],[0].
- tag_in  in  TAG_W  triangle id travelling with the normal.
- normal_valid  in  1  input beat offered.
- in_ready  out  1  block can accept a beat this cycle.
- light_dir  in  48  vec3_f16 light direction, expected already normalised.
- light_load  in  1  latch light_dir this cycle.
- intensity  out  16  f16 result, clamped to >= +0.
- facing  out  1  1 when N·L > 0 and not NaN.
- tag_out  out  TAG_W  tag of the current output beat.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream consumes the beat.

Behaviour:
- Reset (rst low, asynchronous):
  - out_valid=0, intensity=0, facing=0, tag_out=0.
  - in_ready=0 while rst is low; in_ready=1 from the first clk edge after release.
  - Credit counter=0, FIFO emptied.
  - Light register = (x=0x0000, y=0x0000, z=0x3C00).
- Accept: a beat is accepted when normal_valid && in_ready at a clk edge.
- Light register timing:
  - light_load updates the register at the clk edge.
  - A beat accepted on the same edge uses the old light value.
  - Beats accepted later use the new value.
  - In-flight beats are unaffected.
- Datapath:
  - Three float_multiply in parallel: nx*lx, ny*ly, nz*lz.
  - s0 = p_x + p_y on float_add_sub, operation 8'b00000000.
  - p_z is delayed ADD_LAT cycles by a shift register.
  - dot = s0 + p_z_delayed.
  - Pipeline latency L = MUL_LAT + 2*ADD_LAT.
- Tag and valid path: tag and valid travel in a parallel shift register of length L. Tags are never carried through the IP.
- Clamp, applied at the FIFO write:
  - If sign=1, dot==±0, or NaN (exp=0x1F, mant!=0): intensity=0x0000, facing=0.
  - Otherwise intensity=dot, facing=1.
  - +Inf passes through unchanged with facing=1.
- FIFO:
  - Width 16+1+TAG_W, depth DEPTH, first-word-fall-through.
  - Outputs are driven from the registered head.
  - out_valid = FIFO not empty.
  - Pop on out_valid && out_ready.
- Credit counter:
  - Range 0..DEPTH; counts in-flight plus stored beats.
  - +1 on accept, -1 on pop; unchanged on a simultaneous accept and pop.
  - in_ready = (credit < DEPTH). It is combinational from the registered counter and must not depend on out_ready.
  - The FIFO therefore never overflows. The credit counter never underflows, since a pop requires out_valid.
- Timing and ordering:
  - Beat accepted at edge t: out_valid first high after edge t+L+1, when the FIFO was empty.
  - Output order equals acceptance order.
- Output hold: while out_valid=1 and out_ready=0, intensity, facing and tag_out hold stable.
- Throughput: one beat per cycle sustained when out_ready=1.
- Reset mid-operation: all in-flight and buffered beats are discarded and no stale out_valid appears after release. IP internal state is flushed by ignoring its valid for L cycles, gated by the shift-register valid.

Test Plan:
- Light at reset value, normal (0,0,0x3C00), tag 0x0001 → after L+1 cycles: intensity=0x3C00, facing=1, tag_out=0x0001, out_valid one beat.
- Normal (0,0,0xBC00) → intensity=0x0000, facing=0.
- Normal (0,0,0x7E00) (NaN) → intensity=0x0000, facing=0.
- Load light (0x3C00,0x3C00,0x3C00), normal (0x3C00,0x4000,0x4200) i.e. (1,2,3) → intensity=0x4600 (6.0), facing=1.
- out_ready=0, offer DEPTH+4 beats with tags 0..DEPTH+3:
  - in_ready falls after exactly DEPTH accepts and nothing is lost.
  - Raising out_ready drains tags in order 0..DEPTH-1, then the remaining 4 are accepted.
  - out_ready toggled every other cycle: outputs are stable while stalled.
- light_load on the same edge as accepting tag 5 (old light +Z, new light -Z), normal (0,0,0x3C00) for tags 5 and 6:
  - tag 5 → 0x3C00.
  - tag 6 → 0x0000, facing=0.
- Assert rst low with 10 beats in flight and 3 buffered:
  - out_valid=0 immediately.
  - No output appears for L+5 cycles after release.
  - The next accepted beat emerges with the correct value and tag.

Source files
------------

// File: rtl/normal_light_dot.sv
// Flat-shading Lambert stage: max(0, N.L) in f16 against a programmable light,
// with credit-based input flow control and a first-word-fall-through result buffer.
module normal_light_dot #(
  parameter int MUL_LAT = 6,
  parameter int ADD_LAT = 11,
  parameter int TAG_W   = 16,
  parameter int DEPTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [47:0]      normal,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             normal_valid,
  output logic             in_ready,
  input  logic [47:0]      light_dir,
  input  logic             light_load,
  output logic [15:0]      intensity,
  output logic             facing,
  output logic [TAG_W-1:0] tag_out,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int L  = MUL_LAT + 2 * ADD_LAT;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 17 + TAG_W;
  localparam logic [15:0] QNAN      = 16'h7E00;
  localparam logic [47:0] LIGHT_RST = {16'h3C00, 16'h0000, 16'h0000};

  function automatic logic [15:0] round_pack(input logic s, input logic signed [7:0] e,
                                             input logic [10:0] m, input logic g, input logic st);
    logic [11:0] mr;
    logic signed [7:0] er;
    mr = {1'b0, m} + {11'd0, g & (st | m[0])};
    er = e;
    if (mr[11]) begin
      mr = mr >> 1;
      er = er + 8'sd1;
    end
    if (er >= 8'sd31) return {s, 5'h1F, 10'h000};
    if (er <= 8'sd0) return {s, 15'h0000};
    return {s, er[4:0], mr[9:0]};
  endfunction

  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [21:0] p;
    logic signed [7:0] e;
    s      = a[15] ^ b[15];
    a_nan  = (&a[14:10]) && (|a[9:0]);
    b_nan  = (&b[14:10]) && (|b[9:0]);
    a_inf  = (&a[14:10]) && !(|a[9:0]);
    b_inf  = (&b[14:10]) && !(|b[9:0]);
    a_zero = !(|a[14:10]);
    b_zero = !(|b[14:10]);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return QNAN;
    if (a_inf || b_inf) return {s, 5'h1F, 10'h000};
    if (a_zero || b_zero) return {s, 15'h0000};
    p = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    e = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
    if (p[21]) e = e + 8'sd1;
    else       p = p << 1;
    return round_pack(s, e, p[21:11], p[10], |p[9:0]);
  endfunction

  // Subnormal operands are flushed to zero; the larger magnitude sets the result sign.
  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic [4:0]  d;
    logic [39:0] bx, by, by_sh, sum;
    logic        sticky;
    logic signed [7:0] e;
    int lp;
    if (((&a[14:10]) && (|a[9:0])) || ((&b[14:10]) && (|b[9:0]))) return QNAN;
    if ((&a[14:10]) && (&b[14:10])) return (a[15] != b[15]) ? QNAN : a;
    if (&a[14:10]) return a;
    if (&b[14:10]) return b;
    if (!(|a[14:10]) && !(|b[14:10])) return {a[15] & b[15], 15'h0000};
    if (!(|a[14:10])) return b;
    if (!(|b[14:10])) return a;
    if (a[14:0] >= b[14:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d      = x[14:10] - y[14:10];
    bx     = {9'd0, 1'b1, x[9:0], 20'd0};
    by     = {9'd0, 1'b1, y[9:0], 20'd0};
    sticky = |(by & ~({40{1'b1}} << d));
    by_sh  = by >> d;
    by_sh[0] = by_sh[0] | sticky;
    sum    = (x[15] == y[15]) ? (bx + by_sh) : (bx - by_sh);
    if (sum == 40'd0) return 16'h0000;
    lp = 0;
    for (int i = 0; i < 40; i++) if (sum[i]) lp = i;
    e = 8'(int'(x[14:10]) + lp - 30);
    if (lp > 30) sum = (sum >> 1) | {39'd0, sum[0]};
    else         sum = sum << (30 - lp);
    return round_pack(x[15], e, sum[30:20], sum[19], |sum[18:0]);
  endfunction

  // Negative, zero and NaN dot products all collapse to +0 with facing cleared.
  function automatic logic [16:0] clamp(input logic [15:0] dv);
    if (dv[15] || (dv[14:0] == 15'd0) || ((&dv[14:10]) && (|dv[9:0]))) return 17'd0;
    return {dv, 1'b1};
  endfunction

  logic [47:0]      light_q;
  logic             rdy_q;
  logic [CW-1:0]    credit_q, credit_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]    head_q;
  logic             out_valid_q;
  logic [L-1:0]     vld_p;
  logic [15:0]      px_p [MUL_LAT];
  logic [15:0]      py_p [MUL_LAT];
  logic [15:0]      pz_p [MUL_LAT];
  logic [15:0]      s0_p [ADD_LAT];
  logic [15:0]      pzd_p [ADD_LAT];
  logic [15:0]      dot_p [ADD_LAT];
  logic [TAG_W-1:0] tag_p [L];
  logic [EW-1:0]    mem [DEPTH];
  logic             accept, pop, wr, load_head;

  assign in_ready  = rdy_q && (credit_q < CW'(DEPTH));
  assign accept    = normal_valid && in_ready;
  assign pop       = out_valid_q && out_ready;
  assign wr        = vld_p[L-1];
  assign load_head = (!out_valid_q || pop) && (cnt_q != '0);

  assign out_valid = out_valid_q;
  assign intensity = head_q[EW-1 -: 16];
  assign facing    = head_q[TAG_W];
  assign tag_out   = head_q[TAG_W-1:0];

  always_comb begin
    credit_d = credit_q;
    if (accept && !pop)      credit_d = credit_q + 1'b1;
    else if (!accept && pop) credit_d = credit_q - 1'b1;
    cnt_d = cnt_q;
    if (wr && !load_head)      cnt_d = cnt_q + 1'b1;
    else if (!wr && load_head) cnt_d = cnt_q - 1'b1;
  end

  // Stage boundaries: products -> partial sum / delayed pz -> dot -> buffer write.
  always_ff @(posedge clk) begin
    px_p[0]  <= fmul(normal[15:0],  light_q[15:0]);
    py_p[0]  <= fmul(normal[31:16], light_q[31:16]);
    pz_p[0]  <= fmul(normal[47:32], light_q[47:32]);
    for (int i = 1; i < MUL_LAT; i++) begin
      px_p[i] <= px_p[i-1];
      py_p[i] <= py_p[i-1];
      pz_p[i] <= pz_p[i-1];
    end
    s0_p[0]  <= fadd(px_p[MUL_LAT-1], py_p[MUL_LAT-1]);
    pzd_p[0] <= pz_p[MUL_LAT-1];
    dot_p[0] <= fadd(s0_p[ADD_LAT-1], pzd_p[ADD_LAT-1]);
    for (int i = 1; i < ADD_LAT; i++) begin
      s0_p[i]  <= s0_p[i-1];
      pzd_p[i] <= pzd_p[i-1];
      dot_p[i] <= dot_p[i-1];
    end
    tag_p[0] <= tag_in;
    for (int i = 1; i < L; i++) tag_p[i] <= tag_p[i-1];
    if (wr) mem[wr_ptr_q] <= {clamp(dot_p[ADD_LAT-1]), tag_p[L-1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q       <= 1'b0;
      credit_q    <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      vld_p       <= '0;
      light_q     <= LIGHT_RST;
      head_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rdy_q    <= 1'b1;
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
      vld_p    <= {vld_p[L-2:0], accept};
      if (light_load) light_q <= light_dir;
      if (wr) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (load_head) begin
        rd_ptr_q    <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        head_q      <= mem[rd_ptr_q];
        out_valid_q <= 1'b1;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_normal_light_dot.sv
// Scoreboard bench for normal_light_dot: directed normals with hand-computed
// Lambert results, queued at acceptance and checked by an output monitor.
module tb_normal_light_dot;
  localparam int MUL_LAT = 6;
  localparam int ADD_LAT = 11;
  localparam int TAG_W   = 16;
  localparam int DEPTH   = 32;
  localparam int L       = MUL_LAT + 2 * ADD_LAT;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [47:0]      normal = '0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             normal_valid = 1'b0;
  logic             in_ready;
  logic [47:0]      light_dir = '0;
  logic             light_load = 1'b0;
  logic [15:0]      intensity;
  logic             facing;
  logic [TAG_W-1:0] tag_out;
  logic             out_valid;
  logic             out_ready = 1'b0;

  typedef struct packed {
    logic [15:0]      i;
    logic             f;
    logic [TAG_W-1:0] t;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   accepts = 0;

  normal_light_dot #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .normal(normal), .tag_in(tag_in), .normal_valid(normal_valid),
    .in_ready(in_ready), .light_dir(light_dir), .light_load(light_load),
    .intensity(intensity), .facing(facing), .tag_out(tag_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  logic             hold_v = 1'b0;
  logic [15:0]      hold_i;
  logic             hold_f;
  logic [TAG_W-1:0] hold_t;

  always @(negedge clk) begin
    if (!rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid) begin
        check("hold_intensity", intensity, hold_i);
        check("hold_facing", facing, hold_f);
        check("hold_tag", tag_out, hold_t);
      end
      hold_v = out_valid && !out_ready;
      hold_i = intensity;
      hold_f = facing;
      hold_t = tag_out;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", {16'h0, tag_out}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("intensity", intensity, e.i);
          check("facing", facing, e.f);
          check("tag_out", tag_out, e.t);
        end
      end
    end
  end

  task automatic send(input logic [15:0] nx, input logic [15:0] ny, input logic [15:0] nz,
                      input logic [TAG_W-1:0] tag, input logic [15:0] ei, input logic ef,
                      input logic ld, input logic [47:0] lv);
    int w;
    w = 0;
    normal = {nz, ny, nx};
    tag_in = tag;
    normal_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 3000) begin
        check("send_timeout", 32'd0, 32'd1);
        normal_valid = 1'b0;
        return;
      end
    end
    light_load = ld;
    light_dir  = lv;
    sb.push_back('{ei, ef, tag});
    accepts++;
    @(posedge clk);
    #1;
    normal_valid = 1'b0;
    light_load   = 1'b0;
  endtask

  task automatic load_light(input logic [47:0] lv);
    light_dir  = lv;
    light_load = 1'b1;
    @(posedge clk);
    #1;
    light_load = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 1000) begin
      @(posedge clk);
      w++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int stale;
    #1 rst = 1'b0;
    #11;
    check("rst_out_valid", out_valid, 0);
    check("rst_intensity", intensity, 0);
    check("rst_facing", facing, 0);
    check("rst_tag_out", tag_out, 0);
    check("rst_in_ready", in_ready, 0);
    #11 rst = 1'b1;
    #1 check("in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1 check("in_ready_after_edge", in_ready, 1);

    // Reset light is +Z; first beat also measures latency.
    out_ready = 1'b1;
    send(16'h0000, 16'h0000, 16'h3C00, 16'h0001, 16'h3C00, 1'b1, 1'b0, 48'h0);
    k = 0;
    forever begin
      @(negedge clk);
      if (out_valid || k > 200) break;
      k++;
    end
    check("latency", k, L + 1);
    drain();

    send(16'h0000, 16'h0000, 16'hBC00, 16'h0002, 16'h0000, 1'b0, 1'b0, 48'h0);
    send(16'h0000, 16'h0000, 16'h7E00, 16'h0003, 16'h0000, 1'b0, 1'b0, 48'h0);
    send(16'h0000, 16'h0000, 16'h0000, 16'h0004, 16'h0000, 1'b0, 1'b0, 48'h0);
    drain();

    load_light({16'h3C00, 16'h3C00, 16'h3C00});
    send(16'h3C00, 16'h4000, 16'h4200, 16'h0010, 16'h4600, 1'b1, 1'b0, 48'h0);
    send(16'h3C00, 16'hBC00, 16'h0000, 16'h0011, 16'h0000, 1'b0, 1'b0, 48'h0);
    send(16'h3800, 16'h3800, 16'h3800, 16'h0012, 16'h3E00, 1'b1, 1'b0, 48'h0);
    drain();

    // Fill with the consumer stalled, then drain with a toggling out_ready.
    load_light({16'h3C00, 16'h0000, 16'h0000});
    out_ready = 1'b0;
    accepts = 0;
    fork
      begin
        for (int t = 0; t < DEPTH + 4; t++)
          send(16'h0000, 16'h0000, 16'h3C00, TAG_W'(t), 16'h3C00, 1'b1, 1'b0, 48'h0);
      end
      begin
        repeat (DEPTH + L + 10) @(posedge clk);
        @(negedge clk);
        check("in_ready_full", in_ready, 0);
        check("accepts_at_full", accepts, DEPTH);
        for (int c = 0; c < 200; c++) begin
          @(posedge clk);
          #1 out_ready = ~out_ready;
        end
        out_ready = 1'b1;
      end
    join
    check("accepts_total", accepts, DEPTH + 4);
    drain();

    // Light change on the same edge as tag 5: tag 5 sees +Z, tag 6 sees -Z.
    send(16'h0000, 16'h0000, 16'h3C00, 16'h0005, 16'h3C00, 1'b1, 1'b1,
         {16'hBC00, 16'h0000, 16'h0000});
    send(16'h0000, 16'h0000, 16'h3C00, 16'h0006, 16'h0000, 1'b0, 1'b0, 48'h0);
    drain();

    // Reset with three beats buffered and ten in flight.
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++)
      send(16'h0000, 16'h0000, 16'h3C00, TAG_W'(16'h20 + t), 16'h0000, 1'b0, 1'b0, 48'h0);
    repeat (L + 4) @(posedge clk);
    #1;
    for (int t = 0; t < 10; t++)
      send(16'h0000, 16'h0000, 16'h3C00, TAG_W'(16'h30 + t), 16'h0000, 1'b0, 1'b0, 48'h0);
    rst = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_intensity", intensity, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < L + 5; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_out_valid", stale, 0);
    @(posedge clk);
    #1;
    send(16'h0000, 16'h0000, 16'h3C00, 16'h0077, 16'h3C00, 1'b1, 1'b0, 48'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
